// File: rtl/dual_buffer_pkg.sv
// rtl/dual_buffer_pkg.sv - shared defaults, capture state type and status word layout for adc_dual_buffer
package dual_buffer_pkg;

  localparam int          DEF_DATA_WIDTH      = 12;
  localparam int          DEF_BUF_SIZE        = 1024;
  localparam logic [15:0] DEF_READ_STATE_ADDR = 16'h4000;

  typedef enum logic {IDLE, CAPTURE} cap_state_t;

  localparam int ST_HAS_SWITCHED = 0;
  localparam int ST_REG_READ     = 1;
  localparam int ST_CAPTURING    = 2;

  function automatic logic [15:0] status_word(input logic capturing, input logic reg_read,
                                              input logic has_switched);
    logic [15:0] w;
    w                  = '0;
    w[ST_CAPTURING]    = capturing;
    w[ST_REG_READ]     = reg_read;
    w[ST_HAS_SWITCHED] = has_switched;
    return w;
  endfunction

endpackage

// File: rtl/dual_buffer_ram.sv
// rtl/dual_buffer_ram.sv - simple dual-port RAM, one synchronous write port and one synchronous read port
module dual_buffer_ram #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/adc_dual_buffer.sv
// rtl/adc_dual_buffer.sv - ping-pong ADC capture buffer read out over a multiplexed 16-bit host bus
module adc_dual_buffer
  import dual_buffer_pkg::*;
#(
  parameter int          DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int          BUF_SIZE        = DEF_BUF_SIZE,
  parameter logic [15:0] READ_STATE_ADDR = DEF_READ_STATE_ADDR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  adc_clk,
  input  logic [DATA_WIDTH-1:0] sync_adc_data,
  input  logic                  stable,
  input  logic                  sync_signal_in,
  input  logic                  en,
  input  logic                  addr_en,
  input  logic                  rd_en,
  input  logic                  wr_en,
  input  logic [15:0]           rd_data,
  output logic [15:0]           wr_data
);

  localparam int          AW       = $clog2(BUF_SIZE);
  localparam logic [AW-1:0] LAST_PTR = AW'(BUF_SIZE - 1);
  localparam logic [15:0] BUF_LIMIT = 16'(BUF_SIZE);

  cap_state_t             r_state;
  logic                   r_adc_clk_q, r_sig_q, r_rd_en_q;
  logic                   r_write_buf, r_has_switched, r_reg_read;
  logic [AW-1:0]          r_write_ptr;
  logic [15:0]            r_addr, r_wr_data;
  logic                   w_adc_tick, w_trig, w_host_wr, w_ram_we;
  logic [AW:0]            w_raddr, w_waddr;
  logic [DATA_WIDTH-1:0]  w_ram_q;
  logic [15:0]            w_rd_word;

  assign w_adc_tick = adc_clk & ~r_adc_clk_q;
  assign w_trig     = sync_signal_in & ~r_sig_q;
  assign w_host_wr  = en & rd_en & ~r_rd_en_q & (r_addr == READ_STATE_ADDR);
  assign w_ram_we   = (r_state == CAPTURE) & w_adc_tick & stable;
  assign w_waddr    = {r_write_buf, r_write_ptr};
  // Look up the address as it is presented so the RAM word is ready by the first wr_en edge.
  assign w_raddr    = {~r_write_buf, (en & addr_en) ? rd_data[AW-1:0] : r_addr[AW-1:0]};
  assign wr_data    = r_wr_data;

  dual_buffer_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(AW + 1)
  ) u_ram (
    .clk    (clk),
    .i_we   (w_ram_we),
    .i_waddr(w_waddr),
    .i_wdata(sync_adc_data),
    .i_raddr(w_raddr),
    .o_rdata(w_ram_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_adc_clk_q <= 1'b0;
      r_sig_q     <= 1'b0;
      r_rd_en_q   <= 1'b0;
    end else begin
      r_adc_clk_q <= adc_clk;
      r_sig_q     <= sync_signal_in;
      r_rd_en_q   <= rd_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_write_buf    <= 1'b0;
      r_write_ptr    <= '0;
      r_has_switched <= 1'b0;
      r_reg_read     <= 1'b0;
    end else begin
      if (w_host_wr) begin
        r_reg_read <= rd_data[0];
        if (r_reg_read && !rd_data[0]) r_has_switched <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_trig && stable) begin
            r_state     <= CAPTURE;
            r_write_ptr <= '0;
          end
        end
        CAPTURE: begin
          if (!stable) begin
            r_state <= IDLE;
          end else if (w_adc_tick) begin
            if (r_write_ptr == LAST_PTR) begin
              r_write_ptr <= '0;
              r_state     <= IDLE;
              // Old reg_read decides: a host lock landing on this same edge does not block the swap.
              if (!r_reg_read) begin
                r_write_buf    <= ~r_write_buf;
                r_has_switched <= 1'b1;
              end
            end else begin
              r_write_ptr <= r_write_ptr + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (r_addr < BUF_LIMIT)
      w_rd_word = 16'(w_ram_q);
    else if (r_addr == READ_STATE_ADDR)
      w_rd_word = status_word(r_state == CAPTURE, r_reg_read, r_has_switched);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr    <= '0;
      r_wr_data <= '0;
    end else begin
      if (en && addr_en) r_addr <= rd_data;
      if (!en)
        r_wr_data <= '0;
      else if (wr_en)
        r_wr_data <= w_rd_word;
    end
  end

endmodule

// File: tb/tb_adc_dual_buffer.sv
// tb/tb_adc_dual_buffer.sv - directed/randomised bench for adc_dual_buffer against a frame-level model
module tb_adc_dual_buffer;

  localparam int B = 1024;
  localparam logic [15:0] ST = 16'h4000;

  logic        clk = 1'b0;
  logic        rst, adc_clk, stable, sync_signal_in, en, addr_en, rd_en, wr_en;
  logic [11:0] sync_adc_data;
  logic [15:0] rd_data, wr_data;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: RAM image, active write half, host lock and swap flag.
  logic [11:0] m_mem [2*B];
  int          m_wb;
  logic        m_hs, m_rr;

  always #5 clk = ~clk;

  adc_dual_buffer dut (
    .clk(clk), .rst(rst), .adc_clk(adc_clk), .sync_adc_data(sync_adc_data),
    .stable(stable), .sync_signal_in(sync_signal_in), .en(en), .addr_en(addr_en),
    .rd_en(rd_en), .wr_en(wr_en), .rd_data(rd_data), .wr_data(wr_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] m_status(input logic cap);
    return {13'b0, cap, m_rr, m_hs};
  endfunction

  function automatic logic [15:0] m_read(input int a);
    return 16'(m_mem[(m_wb == 0 ? B : 0) + a]);
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    en = 1; addr_en = 1; rd_data = a; step();
    addr_en = 0; rd_data = d; rd_en = 1; step();
    rd_en = 0; en = 0; step();
    if (a == ST) begin
      if (m_rr && !d[0]) m_hs = 0;
      m_rr = d[0];
    end
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    en = 1; addr_en = 1; rd_data = a; step();
    addr_en = 0; wr_en = 1; step();
    check(tag, wr_data, exp);
    step();
    check({tag, "_hold"}, wr_data, exp);
    wr_en = 0; en = 0; step();
    check({tag, "_idle"}, wr_data, 16'h0);
  endtask

  task automatic run_frame(input int offset, input bit rnd, input int abort_at,
                           input int rst_at, input bit chk_cap);
    logic [11:0] d;
    sync_signal_in = 0; step();
    sync_signal_in = 1; step();
    if (chk_cap) read_chk("capturing", ST, m_status(1'b1));
    for (int i = 0; i < B; i++) begin
      d = rnd ? 12'($urandom) : 12'(offset + i);
      sync_adc_data = d;
      if (i == abort_at) begin
        stable = 0; adc_clk = 1; step();
        adc_clk = 0; step();
        stable = 1; step();
        return;
      end
      if (i == rst_at) begin
        rst = 1; sync_signal_in = 0; adc_clk = 0; step(); step();
        rst = 0; step();
        m_wb = 0; m_hs = 0; m_rr = 0;
        return;
      end
      adc_clk = 1; step();
      adc_clk = 0; step();
      m_mem[m_wb*B + i] = d;
    end
    if (!m_rr) begin
      m_wb = 1 - m_wb;
      m_hs = 1;
    end
    step();
  endtask

  initial begin
    int a;
    rst = 1; adc_clk = 0; stable = 1; sync_signal_in = 0; en = 0; addr_en = 0;
    rd_en = 0; wr_en = 0; rd_data = 0; sync_adc_data = 0;
    m_wb = 0; m_hs = 0; m_rr = 0;
    for (int i = 0; i < 2*B; i++) m_mem[i] = '0;

    for (int i = 0; i < 5; i++) step();
    check("rst_wr_data", wr_data, 16'h0);
    rst = 0; step();
    check("post_rst_wr_data", wr_data, 16'h0);
    read_chk("rst_status", ST, 16'h0000);

    run_frame(0, 0, -1, -1, 1);
    read_chk("f1_status", ST, 16'h0001);
    read_chk("f1_addr5", 16'd5, 16'd5);
    read_chk("f1_addr1023", 16'd1023, 16'd1023);
    check("f1_model_addr5", m_read(5), 16'd5);
    for (int k = 0; k < 6; k++) begin
      a = $urandom_range(0, B-1);
      read_chk("f1_rand", 16'(a), m_read(a));
    end

    bus_write(ST, 16'h0001);
    read_chk("lock_status", ST, 16'h0003);
    run_frame(10, 0, -1, -1, 0);
    read_chk("locked_addr5", 16'd5, 16'd5);
    read_chk("locked_status", ST, 16'h0003);
    bus_write(ST, 16'h0000);
    read_chk("unlock_status", ST, 16'h0000);

    run_frame(20, 0, -1, -1, 0);
    read_chk("f3_status", ST, 16'h0001);
    read_chk("f3_addr0", 16'd0, 16'd20);
    read_chk("f3_addr1023", 16'd1023, 16'd1043);

    read_chk("unmapped_2000", 16'h2000, 16'h0000);
    bus_write(16'd7, 16'h0abc);
    read_chk("ignored_wr_addr7", 16'd7, 16'd27);
    read_chk("ignored_wr_status", ST, 16'h0001);
    run_frame(0, 1, 500, -1, 0);
    read_chk("abort_status", ST, m_status(1'b0));
    read_chk("abort_addr5", 16'd5, 16'd25);

    run_frame(0, 1, -1, 300, 0);
    read_chk("midrst_status", ST, 16'h0000);
    run_frame(0, 1, -1, -1, 0);
    read_chk("after_rst_status", ST, 16'h0001);
    read_chk("after_rst_addr0", 16'd0, m_read(0));
    read_chk("after_rst_addr1023", 16'd1023, m_read(1023));
    for (int k = 0; k < 6; k++) begin
      a = $urandom_range(0, B-1);
      read_chk("rnd_frame", 16'(a), m_read(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
